// File: rtl/reduce_gate_pkg.sv
// Shared encodings for the reduce_gate block: reduction op codes and FSM states.
package reduce_gate_pkg;

  localparam logic [1:0] OP_OR  = 2'b00;
  localparam logic [1:0] OP_AND = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOR = 2'b11;

  localparam int unsigned HOLD_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

endpackage

// File: rtl/reduce_gate_core.sv
// Combinational masked reduction; masked-off channels contribute the op's identity element.
module reduce_gate_core
  import reduce_gate_pkg::*;
#(
  parameter int unsigned N_IN = 4
) (
  input  logic [N_IN-1:0] in_vec,
  input  logic [N_IN-1:0] in_mask,
  input  logic [1:0]      op_sel,
  output logic            reduced
);

  logic [N_IN-1:0] vec_or_id;
  logic [N_IN-1:0] vec_and_id;

  assign vec_or_id  = in_vec & in_mask;
  assign vec_and_id = in_vec | ~in_mask;

  always_comb begin
    reduced = 1'b0;
    case (op_sel)
      OP_OR:   reduced = |vec_or_id;
      OP_AND:  reduced = &vec_and_id;
      OP_XOR:  reduced = ^vec_or_id;
      OP_NOR:  reduced = ~|vec_or_id;
      default: reduced = 1'b0;
    endcase
  end

endmodule

// File: rtl/reduce_gate_n.sv
// Reduction gate with pulse stretch, rise detection and saturating event count.
// Optional per-channel sticky activity flags enabled by macro REDUCE_GATE_STICKY_EN.
module reduce_gate_n
  import reduce_gate_pkg::*;
#(
  parameter int unsigned N_IN        = 4,
  parameter int unsigned HOLD_CYCLES = 0,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IN-1:0]  in_vec,
  input  logic [N_IN-1:0]  in_mask,
  input  logic [1:0]       op_sel,
  input  logic [N_IN-1:0]  sticky_clr,
  output logic             output1,
  output logic             rise_pulse,
  output logic [CNT_W-1:0] event_cnt,
  output logic [N_IN-1:0]  sticky_q
);

  // Guarded so HOLD_CYCLES=0 never evaluates a negative load value.
  localparam logic [HOLD_W-1:0] HOLD_LOAD =
    (HOLD_CYCLES > 0) ? HOLD_W'(HOLD_CYCLES - 1) : '0;

  logic              reduced;
  state_t            state, state_d;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_d;
  logic              rise_d;

  reduce_gate_core #(.N_IN(N_IN)) u_core (
    .in_vec  (in_vec),
    .in_mask (in_mask),
    .op_sel  (op_sel),
    .reduced (reduced)
  );

  always_comb begin
    state_d    = state;
    hold_cnt_d = hold_cnt;
    case (state)
      ST_IDLE: begin
        if (reduced) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (!reduced) begin
          if (HOLD_CYCLES > 0) begin
            state_d    = ST_HOLD;
            hold_cnt_d = HOLD_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_HOLD: begin
        if (reduced)              state_d    = ST_ACTIVE;
        else if (hold_cnt == '0)  state_d    = ST_IDLE;
        else                      hold_cnt_d = hold_cnt - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Only a fresh IDLE->ACTIVE entry counts as a rise; HOLD->ACTIVE keeps output1 high.
  assign rise_d = (state == ST_IDLE) && (state_d == ST_ACTIVE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      hold_cnt   <= '0;
      output1    <= 1'b0;
      rise_pulse <= 1'b0;
      event_cnt  <= '0;
    end else begin
      state      <= state_d;
      hold_cnt   <= hold_cnt_d;
      output1    <= (state_d != ST_IDLE);
      rise_pulse <= rise_d;
      if (rise_d && (event_cnt != '1)) event_cnt <= event_cnt + 1'b1;
    end
  end

`ifdef REDUCE_GATE_STICKY_EN
  // Set term is OR'd after the clear so a coincident set wins.
  always_ff @(posedge clk) begin
    if (reset) sticky_q <= '0;
    else       sticky_q <= (sticky_q & ~sticky_clr) | (in_vec & in_mask);
  end
`else
  logic unused_sticky_clr;
  assign unused_sticky_clr = ^sticky_clr;
  assign sticky_q          = '0;
`endif

endmodule

// File: tb/tb_reduce_gate_n.sv
// Self-checking bench for reduce_gate_n (N_IN=4, HOLD_CYCLES=3, CNT_W=4) against a history-based model.
module tb_reduce_gate_n;

  localparam int N_IN  = 4;
  localparam int HOLD  = 3;
  localparam int CNT_W = 4;
  localparam int NEVER = 1000000;

  logic             clk;
  logic             reset;
  logic [N_IN-1:0]  in_vec;
  logic [N_IN-1:0]  in_mask;
  logic [1:0]       op_sel;
  logic [N_IN-1:0]  sticky_clr;
  logic             output1;
  logic             rise_pulse;
  logic [CNT_W-1:0] event_cnt;
  logic [N_IN-1:0]  sticky_q;

  reduce_gate_n #(.N_IN(N_IN), .HOLD_CYCLES(HOLD), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_vec     (in_vec),
    .in_mask    (in_mask),
    .op_sel     (op_sel),
    .sticky_clr (sticky_clr),
    .output1    (output1),
    .rise_pulse (rise_pulse),
    .event_cnt  (event_cnt),
    .sticky_q   (sticky_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  string phase = "init";

  // Model: output1 is high iff reduced was 1 at an edge no more than HOLD edges ago.
  int              since_hit = NEVER;
  logic            m_out = 1'b0;
  logic            m_rise = 1'b0;
  int              m_cnt = 0;
  logic [N_IN-1:0] m_sticky = '0;

  function automatic logic ref_reduce(logic [1:0] op, logic [N_IN-1:0] m, logic [N_IN-1:0] v);
    int n_on = 0;
    int n_hi = 0;
    for (int i = 0; i < N_IN; i++) begin
      if (m[i]) begin
        n_on++;
        if (v[i]) n_hi++;
      end
    end
    case (op)
      2'd0:    return n_hi > 0;
      2'd1:    return n_hi == n_on;
      2'd2:    return (n_hi % 2) == 1;
      default: return n_hi == 0;
    endcase
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: got %0h expected %0h at %0t", phase, name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    logic prev;
    prev = m_out;
    if (reset) begin
      since_hit = NEVER;
      m_out     = 1'b0;
      m_rise    = 1'b0;
      m_cnt     = 0;
      m_sticky  = '0;
    end else begin
      if (ref_reduce(op_sel, in_mask, in_vec)) since_hit = 0;
      else if (since_hit < NEVER)             since_hit++;
      m_out  = (since_hit <= HOLD);
      m_rise = m_out && !prev;
      if (m_rise && m_cnt < (2 ** CNT_W) - 1) m_cnt++;
`ifdef REDUCE_GATE_STICKY_EN
      m_sticky = (m_sticky & ~sticky_clr) | (in_vec & in_mask);
`else
      m_sticky = '0;
`endif
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check("output1", 32'(output1), 32'(m_out));
    check("rise_pulse", 32'(rise_pulse), 32'(m_rise));
    check("event_cnt", 32'(event_cnt), 32'(m_cnt));
    check("sticky_q", 32'(sticky_q), 32'(m_sticky));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  typedef struct {
    logic [1:0]      op;
    logic [N_IN-1:0] mask;
    logic [N_IN-1:0] vec;
    logic            exp;
  } vec_t;

  vec_t tbl[12];

  initial begin
    int hi;
    int rises;
    logic [CNT_W-1:0] cnt_before;

    tbl[0]  = '{2'd0, 4'b1111, 4'b0000, 1'b0};
    tbl[1]  = '{2'd0, 4'b1111, 4'b0100, 1'b1};
    tbl[2]  = '{2'd0, 4'b0000, 4'b1111, 1'b0};
    tbl[3]  = '{2'd1, 4'b0011, 4'b0011, 1'b1};
    tbl[4]  = '{2'd1, 4'b0011, 4'b0001, 1'b0};
    tbl[5]  = '{2'd1, 4'b0000, 4'b0000, 1'b1};
    tbl[6]  = '{2'd2, 4'b1111, 4'b0111, 1'b1};
    tbl[7]  = '{2'd2, 4'b1111, 4'b0110, 1'b0};
    tbl[8]  = '{2'd2, 4'b0000, 4'b1111, 1'b0};
    tbl[9]  = '{2'd3, 4'b1111, 4'b0000, 1'b1};
    tbl[10] = '{2'd3, 4'b0001, 4'b1110, 1'b1};
    tbl[11] = '{2'd3, 4'b1111, 4'b1000, 1'b0};

    reset = 1'b1; in_vec = '0; in_mask = '1; op_sel = 2'd0; sticky_clr = '0;

    phase = "reset";
    step();
    check("rst_output1", 32'(output1), 32'd0);
    check("rst_event_cnt", 32'(event_cnt), 32'd0);
    reset = 1'b0;

    phase = "table";
    for (int i = 0; i < 12; i++) begin
      do_reset();
      op_sel = tbl[i].op; in_mask = tbl[i].mask; in_vec = tbl[i].vec;
      step();
      check($sformatf("tbl%0d_output1", i), 32'(output1), 32'(tbl[i].exp));
    end

    phase = "or_pulse_stretch";
    op_sel = 2'd0; in_mask = 4'b1111; in_vec = '0;
    do_reset();
    step();
    in_vec = 4'b0100;
    step();
    hi = int'(output1); rises = int'(rise_pulse);
    in_vec = '0;
    repeat (6) begin
      step();
      hi += int'(output1); rises += int'(rise_pulse);
    end
    check("high_cycles", 32'(hi), 32'd4);
    check("rise_count", 32'(rises), 32'd1);
    check("event_cnt", 32'(event_cnt), 32'd1);

    phase = "and_hold";
    op_sel = 2'd1; in_mask = 4'b0011; in_vec = 4'b0011;
    do_reset();
    step();
    check("and_on", 32'(output1), 32'd1);
    in_vec = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("and_hold%0d", k), 32'(output1), 32'd1);
    end
    step();
    check("and_off", 32'(output1), 32'd0);

    phase = "hold_reentry";
    op_sel = 2'd0; in_mask = 4'b1111; in_vec = 4'b0001;
    do_reset();
    step();
    cnt_before = event_cnt;
    in_vec = '0;
    step();
    in_vec = 4'b0001;
    step();
    check("reentry_out", 32'(output1), 32'd1);
    check("reentry_no_rise", 32'(rise_pulse), 32'd0);
    check("reentry_cnt", 32'(event_cnt), 32'(cnt_before));
    in_vec = '0;
    repeat (3) begin
      step();
      check("reentry_hold", 32'(output1), 32'd1);
    end
    step();
    check("reentry_off", 32'(output1), 32'd0);

    phase = "mask_change_in_hold";
    in_vec = 4'b0001;
    step();
    in_vec = 4'b0000; in_mask = 4'b0000; op_sel = 2'd1;
    step();
    op_sel = 2'd0;
    repeat (2) begin
      step();
      check("hold_survives", 32'(output1), 32'd1);
    end
    in_mask = 4'b1111;

    phase = "saturate";
    op_sel = 2'd0; in_mask = 4'b1111; in_vec = '0;
    do_reset();
    for (int e = 0; e < 20; e++) begin
      in_vec = 4'b0001;
      step();
      in_vec = '0;
      repeat (5) step();
    end
    check("sat_cnt", 32'(event_cnt), 32'd15);

    phase = "reset_mid_hold";
    in_vec = 4'b0001;
    step();
    in_vec = '0;
    step();
    step();
    reset = 1'b1; in_vec = 4'b1111;
    step();
    check("rst_out", 32'(output1), 32'd0);
    check("rst_cnt", 32'(event_cnt), 32'd0);
    check("rst_sticky", 32'(sticky_q), 32'd0);
    reset = 1'b0;
    step();
    check("post_rst_out", 32'(output1), 32'd1);
    check("post_rst_rise", 32'(rise_pulse), 32'd1);

`ifdef REDUCE_GATE_STICKY_EN
    phase = "sticky";
    in_vec = '0; in_mask = 4'b1111;
    do_reset();
    in_vec = 4'b0100; sticky_clr = 4'b0100;
    step();
    check("sticky_set_wins", 32'(sticky_q), 32'b0100);
    in_vec = '0;
    step();
    check("sticky_clear", 32'(sticky_q), 32'b0000);
    sticky_clr = '0;
`endif

    phase = "random";
    do_reset();
    for (int r = 0; r < 600; r++) begin
      op_sel     = 2'($urandom_range(0, 3));
      in_mask    = 4'($urandom);
      in_vec     = ($urandom_range(0, 2) == 0) ? 4'($urandom) : '0;
      sticky_clr = 4'($urandom);
      reset      = ($urandom_range(0, 49) == 0);
      step();
    end
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
